pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined successor to the team's 16-bit two-level carry-lookahead adder. Supports configurable width, add/subtract mode, carry/borrow-in, and status flags (cout, signed overflow, zero).
- The operand is split into 4-bit lookahead groups. Groups are packed into pipeline stages, and the carry ripples between stages through registers.
- A valid/ready handshake with full-pipeline stall on backpressure lets the block sit in the ALU datapath between the operand fetch and writeback registers.

Parameters:
- WIDTH, 32, operand/sum width; must be a multiple of 4*GROUPS_PER_STAGE.
- GROUPS_PER_STAGE, 4, number of 4-bit CLA groups resolved per pipeline stage (block-level lookahead spans these groups).
- NSTAGE (localparam), WIDTH/(4*GROUPS_PER_STAGE), pipeline depth and latency in cycles.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in (add) / borrow-in (sub).
- in_sub  in  1  0: A+B+cin; 1: A-B-cin.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry out of MSB; for sub, 1 = no borrow.
- out_ovf  out  1  two's-complement signed overflow.
- out_zero  out  1  out_sum == 0.

Behaviour:
- Reset: rst_n sampled low at a rising edge clears all stage valid bits. out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0. Data registers are also cleared to 0.
- Sub mode: internal B' = ~in_b, carry0 = ~in_cin. Add mode: B' = in_b, carry0 = in_cin.
- Per group:
  - p = a^b', g = a&b'; group P = &p, group G by 4-term lookahead.
  - Group carries within a stage come from block lookahead over GROUPS_PER_STAGE groups plus the stage carry-in.
  - Sum bit = p ^ carry.
- Stage k processes slice k. Its carry-in is stage k-1's registered carry-out.
  - Unprocessed upper operand slices and sub flag are carried forward (skew registers).
  - Completed lower sum slices are delayed (deskew registers) so out_sum is aligned.
- Latency: exactly NSTAGE cycles from accept (in_valid&in_ready) to out_valid, with no stall.
- Throughput: one beat per cycle.
- Advance enable: adv = ~out_valid | out_ready. All stages shift together when adv=1 and hold otherwise. in_ready = adv (combinational from out_valid/out_ready only, not from in_valid).
- Bubbles: a stage valid bit is loaded with in_valid&in_ready (stage 0) or the previous valid. Bubbles propagate and are not compressed.
- Flags:
  - ovf = carry into MSB XOR carry out of MSB.
  - zero is computed on the final registered sum (after saturation if enabled).
- out_* are held stable while out_valid=1 and out_ready=0.
- Reset mid-operation: all in-flight beats are discarded; nothing is emitted afterwards. in_ready is 1 in the first cycle after reset.
- NSTAGE=1 degenerates to a single registered output stage.

Optional Feature:
- Macro CLA_SAT_EN.
- When defined: on signed overflow, out_sum saturates to 0111..1 if the true result sign is positive (A sign=0), else 1000..0. out_ovf still reports 1. Saturation is applied in the final stage.
- When undefined: out_sum is the wrapped result; no saturation logic is present.

Decomposition:
- Package cla_pkg holds:
  - GROUP_W = 4
  - function ngroups(width)
  - typedef gp_t (struct: p, g)
  - localparam OP_ADD = 1'b0, OP_SUB = 1'b1
- One sub-module, cla_group4: combinational 4-bit group with inputs a, b, cin and outputs s, P, G. It is instantiated WIDTH/4 times.
- Stage registers and handshake live in the top module.

Test Plan:
- WIDTH=32, GPS=4 (NSTAGE=2): add FFFFFFFF+00000001, cin=0 -> after 2 cycles sum=00000000, cout=1, ovf=0, zero=1.
- Add 7FFFFFFF+00000001 -> sum=80000000, cout=0, ovf=1, zero=0. Sub 80000000-00000001, cin=0 -> sum=7FFFFFFF, cout=1, ovf=1.
- Sub 00000005-00000007, cin=1 -> sum=FFFFFFFD, cout=0, ovf=0.
- Stall ordering: 8 back-to-back random beats with out_ready=0 for cycles 3-5.
  - in_ready=0 exactly while out_valid&~out_ready.
  - Outputs are held stable, all 8 results match the model in order, no drops or duplicates.
- Reset mid-flight: with 2 beats in flight, rst_n=0 for one edge -> out_valid=0 next cycle, all outputs 0, in-flight beats never appear.
- CLA_SAT_EN defined:
  - 7FFFFFFF+00000001 -> sum=7FFFFFFF, ovf=1.
  - 80000000-00000001 -> sum=80000000, ovf=1.
  - Repeat the first case with WIDTH=16, GPS=1 (NSTAGE=4, latency 4).

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    localparam int unsigned GROUP_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic p;
        logic g;
    } gp_t;

    function automatic int unsigned ngroups(input int unsigned width);
        return width / GROUP_W;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group: sum bits plus group propagate/generate.
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] s,
    output logic               P,
    output logic               G
);

    logic [GROUP_W-1:0] pb;
    logic [GROUP_W-1:0] gb;
    logic [GROUP_W-1:0] c;

    assign pb = a ^ b;
    assign gb = a & b;

    // Bit carries in two-level lookahead form, no ripple inside the group.
    assign c[0] = cin;
    assign c[1] = gb[0] | (pb[0] & cin);
    assign c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
    assign c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
                | (pb[2] & pb[1] & pb[0] & cin);

    assign s = pb ^ c;
    assign P = &pb;
    assign G = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
             | (pb[3] & pb[2] & pb[1] & gb[0]);

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/sub CLA with valid/ready handshake; one operand slice per stage.
// Define CLA_SAT_EN to saturate the result on signed overflow.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH            = 32,
    parameter int unsigned GROUPS_PER_STAGE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int unsigned SW      = GROUP_W * GROUPS_PER_STAGE;
    localparam int unsigned NGROUPS = ngroups(WIDTH);
    localparam int unsigned NSTAGE  = NGROUPS / GROUPS_PER_STAGE;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Whole pipeline moves in lockstep; only a stalled output blocks it.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    assign b_eff = (in_sub == OP_SUB) ? ~in_b   : in_b;
    assign c0    = (in_sub == OP_SUB) ? ~in_cin : in_cin;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_st
        localparam int unsigned LO  = k * SW;
        localparam int unsigned REM = WIDTH - LO;

        // Operand bits [WIDTH-1:LO] still to be added, plus the lower sum done so far.
        logic [REM-1:0]             a_s;
        logic [REM-1:0]             b_s;
        logic                       c_s;
        logic                       v_s;
        logic [SW-1:0]              s_s;
        logic [LO+SW-1:0]           sum_d;
        logic                       c_out;
        logic                       term;
        gp_t  [GROUPS_PER_STAGE-1:0] gp;
        logic [GROUPS_PER_STAGE:0]   gc;

        if (k == 0) begin : g_src
            assign a_s   = in_a;
            assign b_s   = b_eff;
            assign c_s   = c0;
            assign v_s   = in_valid & in_ready;
            assign sum_d = s_s;
        end else begin : g_src
            assign a_s   = g_st[k-1].g_reg.a_q;
            assign b_s   = g_st[k-1].g_reg.b_q;
            assign c_s   = g_st[k-1].g_reg.c_q;
            assign v_s   = g_st[k-1].g_reg.v_q;
            assign sum_d = {s_s, g_st[k-1].g_reg.sum_q};
        end

        for (genvar j = 0; j < GROUPS_PER_STAGE; j++) begin : g_grp
            cla_group4 u_grp (
                .a   (a_s[j*GROUP_W +: GROUP_W]),
                .b   (b_s[j*GROUP_W +: GROUP_W]),
                .cin (gc[j]),
                .s   (s_s[j*GROUP_W +: GROUP_W]),
                .P   (gp[j].p),
                .G   (gp[j].g)
            );
        end

        // Block lookahead: each group carry is a flat sum of G/P products and the stage carry-in.
        always_comb begin
            term  = 1'b0;
            gc    = '0;
            gc[0] = c_s;
            for (int j = 0; j < int'(GROUPS_PER_STAGE); j++) begin
                term = c_s;
                for (int i = 0; i <= j; i++) term = term & gp[i].p;
                gc[j+1] = term;
                for (int i = 0; i <= j; i++) begin
                    term = gp[i].g;
                    for (int m = i + 1; m <= j; m++) term = term & gp[m].p;
                    gc[j+1] = gc[j+1] | term;
                end
            end
        end

        assign c_out = gc[GROUPS_PER_STAGE];

        if (k < NSTAGE - 1) begin : g_reg
            logic [REM-SW-1:0] a_q;
            logic [REM-SW-1:0] b_q;
            logic [LO+SW-1:0]  sum_q;
            logic              c_q;
            logic              v_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sum_q <= '0;
                    c_q   <= 1'b0;
                    v_q   <= 1'b0;
                end else if (adv) begin
                    a_q   <= a_s[REM-1:SW];
                    b_q   <= b_s[REM-1:SW];
                    sum_q <= sum_d;
                    c_q   <= c_out;
                    v_q   <= v_s;
                end
            end
        end else begin : g_out
            logic             cmsb;
            logic             ovf_d;
            logic [WIDTH-1:0] res_d;

            // Carry into the MSB recovered from the MSB sum bit and its propagate.
            assign cmsb  = sum_d[WIDTH-1] ^ a_s[REM-1] ^ b_s[REM-1];
            assign ovf_d = cmsb ^ c_out;

`ifdef CLA_SAT_EN
            always_comb begin
                res_d = sum_d;
                if (ovf_d) begin
                    res_d = a_s[REM-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
`else
            assign res_d = sum_d;
`endif

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    out_sum   <= '0;
                    out_cout  <= 1'b0;
                    out_ovf   <= 1'b0;
                    out_zero  <= 1'b0;
                end else if (adv) begin
                    out_valid <= v_s;
                    out_sum   <= res_d;
                    out_cout  <= c_out;
                    out_ovf   <= ovf_d;
                    out_zero  <= (res_d == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench: directed vectors, stall ordering and mid-flight reset.
module tb_pipelined_cla_adder;

    localparam int unsigned NST  = 2;
    localparam int unsigned NST2 = 4;

`ifdef CLA_SAT_EN
    localparam logic [31:0] E_POS_OVF = 32'h7FFF_FFFF;
    localparam logic [31:0] E_NEG_OVF = 32'h8000_0000;
    localparam logic [31:0] E_NN_SUM  = 32'h8000_0000;
    localparam logic        E_NN_Z    = 1'b0;
    localparam logic [31:0] E16_POS   = 32'h0000_7FFF;
`else
    localparam logic [31:0] E_POS_OVF = 32'h8000_0000;
    localparam logic [31:0] E_NEG_OVF = 32'h7FFF_FFFF;
    localparam logic [31:0] E_NN_SUM  = 32'h0000_0000;
    localparam logic        E_NN_Z    = 1'b1;
    localparam logic [31:0] E16_POS   = 32'h0000_8000;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_cin, in_sub;
    logic [31:0] in_a, in_b, out_sum;
    logic        out_valid, out_ready, out_cout, out_ovf, out_zero;

    logic        s_in_valid, s_in_ready, s_in_cin, s_in_sub;
    logic [15:0] s_in_a, s_in_b, s_out_sum;
    logic        s_out_valid, s_out_ready, s_out_cout, s_out_ovf, s_out_zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(32), .GROUPS_PER_STAGE(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    pipelined_cla_adder #(.WIDTH(16), .GROUPS_PER_STAGE(1)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_cin(s_in_cin), .in_sub(s_in_sub),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_sum(s_out_sum), .out_cout(s_out_cout), .out_ovf(s_out_ovf), .out_zero(s_out_zero)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic, returns {sum, cout, ovf, zero}.
    function automatic logic [34:0] model32(input logic [31:0] a, input logic [31:0] b,
                                            input logic cin, input logic sub);
        logic [31:0] bp;
        logic [32:0] full;
        logic [31:0] s;
        logic        ovf;
        bp   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bp} + {32'd0, cin ^ sub};
        s    = full[31:0];
        ovf  = (a[31] == bp[31]) && (s[31] != a[31]);
`ifdef CLA_SAT_EN
        if (ovf) s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {s, full[32], ovf, s == 32'd0};
    endfunction

    task automatic run32(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        in_a = v.a; in_b = v.b; in_cin = v.cin; in_sub = v.sub;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'(NST));
        check($sformatf("v%0d_sum", idx), out_sum, v.sum);
        check($sformatf("v%0d_flags", idx), 32'({out_cout, out_ovf, out_zero}),
              32'({v.cout, v.ovf, v.zero}));
    endtask

    task automatic run16(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        s_in_a = v.a[15:0]; s_in_b = v.b[15:0]; s_in_cin = v.cin; s_in_sub = v.sub;
        s_in_valid = 1'b1; s_out_ready = 1'b1;
        #1;
        check($sformatf("w16_%0d_in_ready", idx), 32'(s_in_ready), 32'd1);
        @(negedge clk);
        s_in_valid = 1'b0;
        lat = 1;
        while (!s_out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("w16_%0d_latency", idx), 32'(lat), 32'(NST2));
        check($sformatf("w16_%0d_sum", idx), 32'(s_out_sum), v.sum);
        check($sformatf("w16_%0d_flags", idx), 32'({s_out_cout, s_out_ovf, s_out_zero}),
              32'({v.cout, v.ovf, v.zero}));
    endtask

    initial begin
        vec_t        vecs[9];
        vec_t        v16[3];
        logic [31:0] ra[8], rb[8];
        logic        rc[8], rs[8];
        logic [34:0] expq[$];
        logic [34:0] e;
        logic [31:0] hsum;
        logic [2:0]  hfl;
        logic        held;
        int          sent, rcvd, stalls, extra, seen;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, E_POS_OVF,     1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, E_NEG_OVF,     1'b1, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, E_NN_SUM,      1'b1, 1'b1, E_NN_Z};
        vecs[8] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};

        v16[0] = '{32'h7FFF, 32'h0001, 1'b0, 1'b0, E16_POS, 1'b0, 1'b1, 1'b0};
        v16[1] = '{32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1};
        v16[2] = '{32'h1234, 32'h0235, 1'b0, 1'b1, 32'h0FFF, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_cin = 1'b0; s_in_sub = 1'b0;
        s_out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sum", out_sum, 32'd0);
        check("rst_flags", 32'({out_cout, out_ovf, out_zero}), 32'd0);
        check("rst16_valid", 32'(s_out_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 9; i++) run32(vecs[i], i);
        for (int i = 0; i < 3; i++) run16(v16[i], i);

        // Back-to-back beats with the sink stalled for three cycles.
        for (int i = 0; i < 8; i++) begin
            ra[i] = $urandom; rb[i] = $urandom;
            rc[i] = 1'($urandom_range(0, 1)); rs[i] = 1'($urandom_range(0, 1));
        end
        sent = 0; rcvd = 0; stalls = 0; held = 1'b0; hsum = '0; hfl = '0;
        for (int cyc = 0; cyc < 60 && rcvd < 8; cyc++) begin
            @(negedge clk);
            if (held) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_sum", out_sum, hsum);
                check("hold_flags", 32'({out_cout, out_ovf, out_zero}), 32'(hfl));
            end
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                in_a = ra[sent]; in_b = rb[sent]; in_cin = rc[sent]; in_sub = rs[sent];
            end
            #1;
            check("stall_in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (in_valid && in_ready) begin
                expq.push_back(model32(in_a, in_b, in_cin, in_sub));
                sent++;
            end
            held = out_valid && !out_ready;
            if (held) begin
                stalls++;
                hsum = out_sum;
                hfl  = {out_cout, out_ovf, out_zero};
            end
            if (out_valid && out_ready) begin
                check("stall_q_nonempty", 32'(expq.size() != 0), 32'd1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    check($sformatf("stall_sum%0d", rcvd), out_sum, e[34:3]);
                    check($sformatf("stall_flags%0d", rcvd),
                          32'({out_cout, out_ovf, out_zero}), 32'(e[2:0]));
                end
                rcvd++;
            end
        end
        in_valid = 1'b0;
        check("stall_sent", 32'(sent), 32'd8);
        check("stall_rcvd", 32'(rcvd), 32'd8);
        check("stall_cycles", 32'(stalls), 32'd3);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check("stall_no_extra", 32'(extra), 32'd0);

        // Reset with two beats in flight, output held so nothing hands off.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        in_a = 32'h7FFF_FFFF; in_b = 32'h1; in_cin = 1'b0; in_sub = 1'b0;
        @(negedge clk);
        in_a = 32'hFFFF_FFFF; in_b = 32'h1;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum", out_sum, 32'd0);
        check("mid_rst_flags", 32'({out_cout, out_ovf, out_zero}), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid_rst_no_ghost", 32'(seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
